mmio_bridge: RTL and testbench
==============================

Name: mmio_bridge

Overview:
- Registered, parametrised successor to the combinational CPU-to-bus MMU.
- Accepts one CPU load/store at a time and decodes the slave number from the top address bits.
- Checks alignment, mode validity and the slave map, then runs a request/ready handshake on the slave bus with a timeout.
- Returns lane-aligned, sign/zero-extended read data, or a fault with a cause code. Sits between the CPU LSU and the slave bus.

Parameters:
- XLEN, 32, data/address width (must be 32; lane logic assumes 4 bytes).
- SLAVE_WIDTH, 4, number of top address bits selecting the slave.
- SLAVE_MAP, 16'h1501, bit i = 1 means slave number i exists (defaults: IMEM 0x0, DMEM 0x8, DEVICE 0xa, FB 0xc); width is 2**SLAVE_WIDTH.
- TIMEOUT, 255, max cycles spent in BUS before abort (1..2**16-1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_req  in  1  CPU request valid; held until mem_ready.
- mem_wen  in  1  1 = store.
- mem_mode  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- mem_addr  in  XLEN  byte address.
- mem_dat_i  in  XLEN  store data, value in low bits.
- mem_dat_o  out  XLEN  load result, extended.
- mem_ready  out  1  one-cycle completion pulse.
- mem_fault  out  1  valid with mem_ready; 1 = access failed.
- fault_cause  out  2  00 none, 01 misaligned, 10 decode, 11 timeout.
- bus_dat_i  in  XLEN  slave read data, 32-bit word, lanes by addr[1:0].
- bus_dat_o  out  XLEN  lane-replicated store data.
- bus_addr  out  XLEN-SLAVE_WIDTH  low address bits, byte granular.
- bus_num  out  SLAVE_WIDTH  slave select, mem_addr top bits.
- bus_req  out  1  bus request.
- bus_wen  out  1  bus write enable.
- bus_mode  out  3  mem_mode forwarded.
- bus_ready_i  in  1  slave completion.

Behaviour:
- Reset: state IDLE; every output 0. Asserting rst_n low mid-transaction drops bus_req immediately and aborts with no mem_ready.
- FSM IDLE -> BUS -> DONE -> IDLE; IDLE -> DONE on a fault detected at accept.
- Requests are accepted only in IDLE with mem_req = 1. mem_req in BUS or DONE is ignored.
- At accept, checks in priority order:
  - Decode (10): mode is 011, 11x, or SLAVE_MAP[addr top bits] = 0.
  - Misaligned (01): h/hu with addr[0] = 1, or w with addr[1:0] != 0.
- Fault at accept: the next cycle is DONE with mem_ready = 1, mem_fault = 1, cause set, mem_dat_o = 0. bus_req is never asserted.
- Otherwise latch bus_num, bus_addr, bus_wen, bus_mode and bus_dat_o, then enter BUS.
- bus_dat_o lanes: b → byte replicated ×4; h → half replicated ×2; w → unchanged.
- In BUS: bus_req = 1 and all bus_* outputs stay stable. Outside BUS: bus_req = 0, bus_wen = 0, other bus_* outputs hold their last value.
- Timeout counter clears at accept and increments each BUS cycle.
- bus_ready_i = 1 in BUS (counter < TIMEOUT, or same cycle it reaches TIMEOUT — ready wins) → DONE.
  - On a read, mem_dat_o is registered as bus_dat_i >> (8*addr[1:0]), then sign-extended (b, h) or zero-extended (bu, hu); w is unchanged.
  - On a write, mem_dat_o = 0.
- Counter == TIMEOUT with no ready → DONE, cause 11, mem_dat_o = 0. A bus_ready_i arriving after the abort is ignored.
- DONE lasts exactly one cycle, with mem_ready = 1. mem_dat_o, mem_fault and fault_cause hold until the next accept.
- Latency: zero-wait slave (ready in the first BUS cycle) gives mem_ready 2 cycles after the accept edge. A fault gives mem_ready 1 cycle after accept. Minimum back-to-back issue interval is 3 cycles.

Test Plan:
- lw 0x8000_0010 with ready delayed 2 cycles, bus_dat_i = 0xDEADBEEF → bus_num = 8, bus_addr = 0x0000010, bus_req high 3 cycles; mem_ready 4 cycles after accept, mem_dat_o = 0xDEADBEEF, fault 0.
- lb 0xA000_0003 with bus_dat_i = 0x80FF_0000 → mem_dat_o = 0xFFFF_FF80. Same request as lbu → mem_dat_o = 0x0000_0080.
- sh 0xC000_0002 with mem_dat_i = 0x1234_ABCD → bus_dat_o = 0xABCD_ABCD, bus_wen = 1, bus_mode = 001; after ready, mem_fault = 0.
- lw 0x8000_0002 → mem_ready next cycle, fault 1, cause 01, bus_req never high. lw 0x1000_0000 → cause 10. mode 011 at a valid address → cause 10.
- TIMEOUT = 4, bus_ready_i tied 0 → bus_req high 5 cycles, then mem_ready with cause 11. A later ready pulse has no effect and the next request is accepted normally.
- rst_n low during BUS → bus_req = 0 at once, no mem_ready. After release a fresh lw completes normally.

Source files
------------

// File: rtl/mmio_bridge.sv
// mmio_bridge: registered CPU-to-slave-bus bridge (decode/alignment checks, req/ready handshake with timeout, lane-aligned extended loads, fault cause out)
module mmio_bridge #(
  parameter int XLEN = 32,
  parameter int SLAVE_WIDTH = 4,
  parameter logic [2**SLAVE_WIDTH-1:0] SLAVE_MAP = 16'h1501,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mem_req,
  input  logic                        mem_wen,
  input  logic [2:0]                  mem_mode,
  input  logic [XLEN-1:0]             mem_addr,
  input  logic [XLEN-1:0]             mem_dat_i,
  output logic [XLEN-1:0]             mem_dat_o,
  output logic                        mem_ready,
  output logic                        mem_fault,
  output logic [1:0]                  fault_cause,
  input  logic [XLEN-1:0]             bus_dat_i,
  output logic [XLEN-1:0]             bus_dat_o,
  output logic [XLEN-SLAVE_WIDTH-1:0] bus_addr,
  output logic [SLAVE_WIDTH-1:0]      bus_num,
  output logic                        bus_req,
  output logic                        bus_wen,
  output logic [2:0]                  bus_mode,
  input  logic                        bus_ready_i
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  localparam logic [15:0] TO = 16'(TIMEOUT);
  state_t state;
  logic [15:0] cnt;
  logic [SLAVE_WIDTH-1:0] num;
  logic dec_err, mis_err;
  logic [XLEN-1:0] wr_lanes, shifted, rd_ext;
  assign num = mem_addr[XLEN-1 -: SLAVE_WIDTH];
  assign dec_err = mem_mode == 3'b011 || mem_mode[2:1] == 2'b11 || !SLAVE_MAP[num];
  assign mis_err = (mem_mode[1:0] == 2'b01 && mem_addr[0]) || (mem_mode[1:0] == 2'b10 && mem_addr[1:0] != 2'b00);
  assign wr_lanes = mem_mode[1:0] == 2'b00 ? {4{mem_dat_i[7:0]}} :
                    mem_mode[1:0] == 2'b01 ? {2{mem_dat_i[15:0]}} : mem_dat_i;
  assign shifted = bus_dat_i >> {bus_addr[1:0], 3'b000};
  assign rd_ext = bus_mode[1:0] == 2'b00 ? {{24{!bus_mode[2] & shifted[7]}}, shifted[7:0]} :
                  bus_mode[1:0] == 2'b01 ? {{16{!bus_mode[2] & shifted[15]}}, shifted[15:0]} : shifted;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      mem_dat_o <= '0;
      mem_ready <= 1'b0;
      mem_fault <= 1'b0;
      fault_cause <= 2'b00;
      bus_dat_o <= '0;
      bus_addr <= '0;
      bus_num <= '0;
      bus_req <= 1'b0;
      bus_wen <= 1'b0;
      bus_mode <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          if (mem_req) begin
            cnt <= '0;
            mem_dat_o <= '0;
            mem_fault <= dec_err || mis_err;
            fault_cause <= dec_err ? 2'b10 : mis_err ? 2'b01 : 2'b00;
            if (dec_err || mis_err) begin
              state <= DONE;
              mem_ready <= 1'b1;
            end else begin
              state <= BUS;
              bus_req <= 1'b1;
              bus_wen <= mem_wen;
              bus_num <= num;
              bus_addr <= mem_addr[XLEN-SLAVE_WIDTH-1:0];
              bus_mode <= mem_mode;
              bus_dat_o <= wr_lanes;
            end
          end
        end
        BUS: begin
          // ready in the same cycle the counter hits TIMEOUT still completes the access
          if (bus_ready_i || cnt == TO) begin
            state <= DONE;
            mem_ready <= 1'b1;
            bus_req <= 1'b0;
            bus_wen <= 1'b0;
            mem_fault <= !bus_ready_i;
            fault_cause <= bus_ready_i ? 2'b00 : 2'b11;
            mem_dat_o <= bus_ready_i && !bus_wen ? rd_ext : '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          mem_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed plus randomized checks of mmio_bridge against a behavioural model
module tb_mmio_bridge;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_req = 1'b0;
  logic mem_wen = 1'b0;
  logic [2:0] mem_mode = 3'b000;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_dat_i = '0;
  logic [31:0] mem_dat_o;
  logic mem_ready, mem_fault;
  logic [1:0] fault_cause;
  logic [31:0] bus_dat_i = '0;
  logic [31:0] bus_dat_o;
  logic [27:0] bus_addr;
  logic [3:0] bus_num;
  logic bus_req, bus_wen;
  logic [2:0] bus_mode;
  logic bus_ready_i = 1'b0;
  logic [15:0] slave_map = 16'h1501;
  int checks = 0;
  int failures = 0;
  mmio_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_wen(mem_wen), .mem_mode(mem_mode),
    .mem_addr(mem_addr), .mem_dat_i(mem_dat_i), .mem_dat_o(mem_dat_o), .mem_ready(mem_ready),
    .mem_fault(mem_fault), .fault_cause(fault_cause), .bus_dat_i(bus_dat_i), .bus_dat_o(bus_dat_o),
    .bus_addr(bus_addr), .bus_num(bus_num), .bus_req(bus_req), .bus_wen(bus_wen),
    .bus_mode(bus_mode), .bus_ready_i(bus_ready_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_ready"}, 32'(mem_ready), 32'd0);
    chk({tag, "_wen"}, 32'(bus_wen), 32'd0);
  endtask
  // Issue one access from an IDLE negedge; the slave raises ready in BUS cycle index `delay`.
  task automatic txn(input logic wen, input logic [2:0] mode, input logic [31:0] addr,
                     input logic [31:0] wdat, input logic [31:0] rword, input int delay);
    int sz, nb, lat, exp_nreq, exp_lat;
    logic dec, mis;
    logic [1:0] exp_cause;
    logic [31:0] exp_data, exp_bdo, v;
    sz = mode[1:0] == 2'b00 ? 1 : mode[1:0] == 2'b01 ? 2 : 4;
    dec = mode == 3'd3 || mode >= 3'd6 || slave_map[addr[31:28]] == 1'b0;
    mis = (addr % sz) != 0;
    exp_cause = dec ? 2'd2 : mis ? 2'd1 : delay > TO ? 2'd3 : 2'd0;
    exp_nreq = (dec || mis) ? 0 : delay > TO ? TO + 1 : delay + 1;
    exp_lat = (dec || mis) ? 1 : exp_nreq + 1;
    v = rword >> (8 * (addr % 4));
    if (sz == 1) begin
      v = v % 256;
      if (!mode[2] && v >= 128) v = v - 256;
    end else if (sz == 2) begin
      v = v % 65536;
      if (!mode[2] && v >= 32768) v = v - 65536;
    end
    exp_data = (exp_cause != 0 || wen) ? 32'd0 : v;
    exp_bdo = sz == 1 ? (wdat % 256) * 32'h0101_0101 : sz == 2 ? (wdat % 65536) * 32'h0001_0001 : wdat;
    mem_req = 1'b1;
    mem_wen = wen;
    mem_mode = mode;
    mem_addr = addr;
    mem_dat_i = wdat;
    bus_dat_i = rword;
    bus_ready_i = 1'b0;
    nb = 0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus_req) begin
        nb++;
        chk("bus_num", 32'(bus_num), 32'(addr[31:28]));
        chk("bus_addr", 32'(bus_addr), 32'(addr[27:0]));
        chk("bus_wen", 32'(bus_wen), 32'(wen));
        chk("bus_mode", 32'(bus_mode), 32'(mode));
        chk("bus_dat_o", bus_dat_o, exp_bdo);
        bus_ready_i = (nb - 1 == delay);
      end else begin
        bus_ready_i = 1'b0;
      end
      if (mem_ready) begin
        lat = c;
        break;
      end
    end
    mem_req = 1'b0;
    bus_ready_i = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("req_cycles", 32'(nb), 32'(exp_nreq));
    chk("mem_fault", 32'(mem_fault), 32'(exp_cause != 0));
    chk("fault_cause", 32'(fault_cause), 32'(exp_cause));
    chk("mem_dat_o", mem_dat_o, exp_data);
    @(negedge clk);
    chk_idle_outputs("after_done");
    chk("dat_hold", mem_dat_o, exp_data);
    chk("cause_hold", 32'(fault_cause), 32'(exp_cause));
  endtask
  initial begin
    #1;
    chk("rst_dat", mem_dat_o, 32'd0);
    chk("rst_fault", {30'd0, mem_fault, mem_ready}, 32'd0);
    chk("rst_cause", 32'(fault_cause), 32'd0);
    chk("rst_bus", {bus_num, bus_addr}, 32'd0);
    chk("rst_bdo", bus_dat_o, 32'd0);
    chk("rst_mode", {27'd0, bus_req, bus_wen, bus_mode}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(1'b0, 3'b010, 32'h8000_0010, 32'd0, 32'hDEAD_BEEF, 2);
    chk("lw_data", mem_dat_o, 32'hDEAD_BEEF);
    chk("lw_num", 32'(bus_num), 32'd8);
    chk("lw_addr", 32'(bus_addr), 32'h0000010);
    txn(1'b0, 3'b000, 32'hA000_0003, 32'd0, 32'h80FF_0000, 0);
    chk("lb_data", mem_dat_o, 32'hFFFF_FF80);
    txn(1'b0, 3'b100, 32'hA000_0003, 32'd0, 32'h80FF_0000, 1);
    chk("lbu_data", mem_dat_o, 32'h0000_0080);
    txn(1'b1, 3'b001, 32'hC000_0002, 32'h1234_ABCD, 32'hFFFF_FFFF, 1);
    chk("sh_bdo", bus_dat_o, 32'hABCD_ABCD);
    chk("sh_mode", 32'(bus_mode), 32'd1);
    chk("sh_fault", 32'(mem_fault), 32'd0);
    txn(1'b0, 3'b010, 32'h8000_0002, 32'd0, 32'h0, 0);
    chk("mis_cause", 32'(fault_cause), 32'd1);
    txn(1'b0, 3'b010, 32'h1000_0000, 32'd0, 32'h0, 0);
    chk("dec_cause", 32'(fault_cause), 32'd2);
    txn(1'b0, 3'b011, 32'h8000_0000, 32'd0, 32'h0, 0);
    chk("mode_cause", 32'(fault_cause), 32'd2);
    txn(1'b0, 3'b101, 32'h0000_0002, 32'd0, 32'h8001_0000, TO);
    chk("hu_ready_at_limit", mem_dat_o, 32'h0000_8001);
    txn(1'b0, 3'b010, 32'h8000_0000, 32'd0, 32'h5555_5555, 99);
    chk("to_cause", 32'(fault_cause), 32'd3);
    bus_ready_i = 1'b1;
    @(negedge clk);
    bus_ready_i = 1'b0;
    chk_idle_outputs("late_ready");
    chk("late_ready_cause", 32'(fault_cause), 32'd3);
    txn(1'b0, 3'b001, 32'hA000_0006, 32'd0, 32'h7FFF_1234, 3);
    chk("after_to_data", mem_dat_o, 32'h0000_7FFF);
    mem_req = 1'b1;
    mem_mode = 3'b010;
    mem_wen = 1'b0;
    mem_addr = 32'h8000_0000;
    @(negedge clk);
    mem_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", 32'(bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    chk("async_rst_bus", {bus_num, bus_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle_outputs("post_rst");
    end
    txn(1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hCAFE_F00D, 0);
    chk("post_rst_data", mem_dat_o, 32'hCAFE_F00D);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [2:0] m;
      m = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[31:28] = 4'($urandom_range(0, 3) * 2 + 8) & (($urandom_range(0, 3) == 0) ? 4'h0 : 4'hF);
      if ($urandom_range(0, 3) != 0) a[1:0] = m[1:0] == 2'b10 ? 2'b00 : m[1:0] == 2'b01 ? {a[1], 1'b0} : a[1:0];
      txn(1'($urandom_range(0, 1)), m, a, $urandom, $urandom, int'($urandom_range(0, 6)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
